// File: rtl/l1_dcache_controller.sv
// L1 data-cache controller: read-allocate, write-through, no-write-allocate.
// The cache arrays sit outside this block. It sequences lookup, memory access and fill, and keeps hit/miss statistics.
module l1_dcache_controller #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16,
  parameter int CNT_W  = 16
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_cpu_req,
  input  logic              i_cpu_we,
  input  logic [ADDR_W-1:0] i_cpu_addr,
  input  logic [DATA_W-1:0] i_cpu_wdata,
  output logic              o_cpu_ready,
  output logic [DATA_W-1:0] o_cpu_rdata,
  output logic              o_cpu_busy,
  output logic [ADDR_W-1:0] o_l1_addr,
  input  logic              i_l1_hit,
  input  logic [DATA_W-1:0] i_l1_rdata,
  output logic              o_l1_wr_en,
  output logic              o_l1_fill_en,
  output logic [DATA_W-1:0] o_l1_wdata,
  output logic              o_mem_req,
  output logic              o_mem_we,
  output logic [ADDR_W-1:0] o_mem_addr,
  output logic [DATA_W-1:0] o_mem_wdata,
  input  logic              i_mem_ack,
  input  logic [DATA_W-1:0] i_mem_rdata,
  output logic [CNT_W-1:0]  o_hit_count,
  output logic [CNT_W-1:0]  o_miss_count
);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_LOOKUP    = 3'd1,
    S_MEM_READ  = 3'd2,
    S_FILL      = 3'd3,
    S_MEM_WRITE = 3'd4,
    S_RESPOND   = 3'd5
  } state_t;

  state_t            r_state;
  logic              r_we;
  logic              r_hit_flag;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata;
  logic [DATA_W-1:0] r_rdata;
  logic [DATA_W-1:0] r_l1_wdata;
  logic              r_ready;
  logic              r_fill_en;
  logic              r_mem_req;
  logic              r_mem_we;
  logic [CNT_W-1:0]  r_hit_cnt;
  logic [CNT_W-1:0]  r_miss_cnt;
  logic              w_l1_wr_en;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + {{(CNT_W-1){1'b0}}, 1'b1};
  endfunction

  // The write-hit strobe must coincide with the ack cycle, so it is decoded from the ack rather than registered.
  assign w_l1_wr_en = (r_state == S_MEM_WRITE) && r_mem_req && i_mem_ack && r_hit_flag && !i_reset;

  assign o_cpu_ready  = r_ready;
  assign o_cpu_rdata  = r_rdata;
  assign o_cpu_busy   = (r_state != S_IDLE);
  assign o_l1_addr    = r_addr;
  assign o_l1_wr_en   = w_l1_wr_en;
  assign o_l1_fill_en = r_fill_en;
  assign o_l1_wdata   = r_l1_wdata;
  assign o_mem_req    = r_mem_req;
  assign o_mem_we     = r_mem_we;
  assign o_mem_addr   = r_addr;
  assign o_mem_wdata  = r_wdata;
  assign o_hit_count  = r_hit_cnt;
  assign o_miss_count = r_miss_cnt;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state    <= S_IDLE;
      r_we       <= 1'b0;
      r_hit_flag <= 1'b0;
      r_addr     <= {ADDR_W{1'b0}};
      r_wdata    <= {DATA_W{1'b0}};
      r_rdata    <= {DATA_W{1'b0}};
      r_l1_wdata <= {DATA_W{1'b0}};
      r_ready    <= 1'b0;
      r_fill_en  <= 1'b0;
      r_mem_req  <= 1'b0;
      r_mem_we   <= 1'b0;
      r_hit_cnt  <= {CNT_W{1'b0}};
      r_miss_cnt <= {CNT_W{1'b0}};
    end else begin
      r_ready   <= 1'b0;
      r_fill_en <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (i_cpu_req) begin
            r_we    <= i_cpu_we;
            r_addr  <= i_cpu_addr;
            r_wdata <= i_cpu_wdata;
            r_state <= S_LOOKUP;
          end
        end
        S_LOOKUP: begin
          if (r_we) begin
            r_hit_flag <= i_l1_hit;
            if (i_l1_hit) r_hit_cnt <= sat_inc(r_hit_cnt);
            else          r_miss_cnt <= sat_inc(r_miss_cnt);
            r_l1_wdata <= r_wdata;
            r_mem_req  <= 1'b1;
            r_mem_we   <= 1'b1;
            r_state    <= S_MEM_WRITE;
          end else if (i_l1_hit) begin
            r_rdata   <= i_l1_rdata;
            r_hit_cnt <= sat_inc(r_hit_cnt);
            r_ready   <= 1'b1;
            r_state   <= S_RESPOND;
          end else begin
            r_miss_cnt <= sat_inc(r_miss_cnt);
            r_mem_req  <= 1'b1;
            r_mem_we   <= 1'b0;
            r_state    <= S_MEM_READ;
          end
        end
        S_MEM_READ: begin
          if (i_mem_ack) begin
            r_rdata    <= i_mem_rdata;
            r_l1_wdata <= i_mem_rdata;
            r_mem_req  <= 1'b0;
            r_fill_en  <= 1'b1;
            r_state    <= S_FILL;
          end
        end
        S_FILL: begin
          r_ready <= 1'b1;
          r_state <= S_RESPOND;
        end
        S_MEM_WRITE: begin
          if (i_mem_ack) begin
            r_mem_req <= 1'b0;
            r_mem_we  <= 1'b0;
            r_ready   <= 1'b1;
            r_state   <= S_RESPOND;
          end
        end
        S_RESPOND: begin
          r_addr  <= {ADDR_W{1'b0}};
          r_state <= S_IDLE;
        end
        default: begin
          r_mem_req <= 1'b0;
          r_mem_we  <= 1'b0;
          r_addr    <= {ADDR_W{1'b0}};
          r_state   <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_l1_dcache_controller.sv
// Randomized bench for l1_dcache_controller: the environment models the L1 arrays and the backing memory.
// A transaction-level reference predicts the data, latency, strobes and counters.
module tb_l1_dcache_controller;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset = 1'b1;
  logic        cpu_req = 1'b0, cpu_we = 1'b0;
  logic [15:0] cpu_addr = 16'd0, cpu_wdata = 16'd0;
  logic        l1_hit, mem_ack = 1'b0;
  logic [15:0] l1_rdata, mem_rdata = 16'd0;

  logic        cpu_ready, cpu_busy, l1_wr_en, l1_fill_en, mem_req, mem_we;
  logic [15:0] cpu_rdata, l1_addr, l1_wdata, mem_addr, mem_wdata, hit_count, miss_count;
  logic        s_ready, s_busy, s_wr_en, s_fill_en, s_mem_req, s_mem_we;
  logic [15:0] s_rdata, s_l1_addr, s_l1_wdata, s_mem_addr, s_mem_wdata;
  logic [1:0]  s_hit_count, s_miss_count;

  l1_dcache_controller #(.ADDR_W(16), .DATA_W(16), .CNT_W(16)) dut (
    .i_clk(clk), .i_reset(reset), .i_cpu_req(cpu_req), .i_cpu_we(cpu_we),
    .i_cpu_addr(cpu_addr), .i_cpu_wdata(cpu_wdata), .o_cpu_ready(cpu_ready),
    .o_cpu_rdata(cpu_rdata), .o_cpu_busy(cpu_busy), .o_l1_addr(l1_addr),
    .i_l1_hit(l1_hit), .i_l1_rdata(l1_rdata), .o_l1_wr_en(l1_wr_en),
    .o_l1_fill_en(l1_fill_en), .o_l1_wdata(l1_wdata), .o_mem_req(mem_req),
    .o_mem_we(mem_we), .o_mem_addr(mem_addr), .o_mem_wdata(mem_wdata),
    .i_mem_ack(mem_ack), .i_mem_rdata(mem_rdata), .o_hit_count(hit_count),
    .o_miss_count(miss_count));

  // Narrow-counter copy sharing every input, used to observe saturation.
  l1_dcache_controller #(.ADDR_W(16), .DATA_W(16), .CNT_W(2)) u_sat (
    .i_clk(clk), .i_reset(reset), .i_cpu_req(cpu_req), .i_cpu_we(cpu_we),
    .i_cpu_addr(cpu_addr), .i_cpu_wdata(cpu_wdata), .o_cpu_ready(s_ready),
    .o_cpu_rdata(s_rdata), .o_cpu_busy(s_busy), .o_l1_addr(s_l1_addr),
    .i_l1_hit(l1_hit), .i_l1_rdata(l1_rdata), .o_l1_wr_en(s_wr_en),
    .o_l1_fill_en(s_fill_en), .o_l1_wdata(s_l1_wdata), .o_mem_req(s_mem_req),
    .o_mem_we(s_mem_we), .o_mem_addr(s_mem_addr), .o_mem_wdata(s_mem_wdata),
    .i_mem_ack(mem_ack), .i_mem_rdata(mem_rdata), .o_hit_count(s_hit_count),
    .o_miss_count(s_miss_count));

  // Environment: L1 arrays and backing memory over a 64-word window.
  logic [15:0] env_l1_data [64];
  bit          env_l1_vld  [64];
  logic [15:0] env_mem     [64];
  assign l1_hit   = (l1_addr < 16'd64) && env_l1_vld[l1_addr[5:0]];
  assign l1_rdata = env_l1_data[l1_addr[5:0]];

  // Reference model: memory contents, the set of cached lines, and the expected counters.
  logic [15:0] ref_mem    [64];
  bit          ref_cached [64];
  int          exp_hit = 0, exp_miss = 0;
  logic [15:0] exp_rdata = 16'd0;

  int n_vec = 0, n_err = 0;
  int n_fill = 0, n_wr = 0, n_ready = 0, n_memacc = 0, n_both = 0, mem_wait = 0;
  int g_ack_delay = 1;
  bit ack_inject = 1'b0;
  logic [15:0] last_fill = 16'd0, last_wr = 16'd0, last_mem_addr = 16'd0, last_mem_wdata = 16'd0;
  logic        last_mem_we = 1'b0;

  task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // Memory responder and strobe monitor; it acks after g_ack_delay cycles of mem_req and samples strobes mid-cycle.
  always @(negedge clk) begin
    if (mem_ack) begin
      mem_ack = 1'b0;
      check_val("mem_req_drop", 32'(mem_req), 32'd0);
    end else if (ack_inject) begin
      mem_ack    = 1'b1;
      ack_inject = 1'b0;
    end else if (mem_req) begin
      mem_wait++;
      if (mem_wait >= g_ack_delay) begin
        mem_ack  = 1'b1;
        mem_wait = 0;
        n_memacc++;
        last_mem_addr  = mem_addr;
        last_mem_we    = mem_we;
        last_mem_wdata = mem_wdata;
        if (mem_we) env_mem[mem_addr[5:0]] = mem_wdata;
        else        mem_rdata = env_mem[mem_addr[5:0]];
      end
    end else begin
      mem_wait = 0;
    end
    #1;
    if (l1_fill_en && l1_wr_en) n_both++;
    if (l1_fill_en) begin
      n_fill++;
      last_fill = l1_wdata;
      env_l1_vld[l1_addr[5:0]]  = 1'b1;
      env_l1_data[l1_addr[5:0]] = l1_wdata;
    end
    if (l1_wr_en) begin
      n_wr++;
      last_wr = l1_wdata;
      env_l1_data[l1_addr[5:0]] = l1_wdata;
    end
    if (cpu_ready) n_ready++;
  end

  task automatic check_counters();
    check_val("hit_count", 32'(hit_count), 32'(exp_hit));
    check_val("miss_count", 32'(miss_count), 32'(exp_miss));
    check_val("sat_hit", 32'(s_hit_count), 32'((exp_hit > 3) ? 3 : exp_hit));
    check_val("sat_miss", 32'(s_miss_count), 32'((exp_miss > 3) ? 3 : exp_miss));
  endtask

  task automatic check_idle_outputs();
    check_val("rst_ready", 32'(cpu_ready), 32'd0);
    check_val("rst_busy", 32'(cpu_busy), 32'd0);
    check_val("rst_mem_req", 32'({mem_req, mem_we}), 32'd0);
    check_val("rst_strobes", 32'({l1_wr_en, l1_fill_en}), 32'd0);
    check_val("rst_addr", 32'({l1_addr, mem_addr}), 32'd0);
    check_val("rst_data", 32'({l1_wdata, mem_wdata}), 32'd0);
    check_val("rst_rdata", 32'(cpu_rdata), 32'd0);
    check_counters();
  endtask

  task automatic access(input bit we, input logic [15:0] a, input logic [15:0] d,
                        input int dly, input bit poke);
    int  b_fill = n_fill, b_wr = n_wr, b_ready = n_ready, b_mem = n_memacc;
    bit  was_hit = ref_cached[a[5:0]];
    int  lat = 0;
    int  exp_lat;
    g_ack_delay = dly;
    cpu_req = 1'b1; cpu_we = we; cpu_addr = a; cpu_wdata = d;
    @(posedge clk); #1;
    cpu_req = 1'b0; cpu_we = 1'($urandom); cpu_addr = 16'($urandom); cpu_wdata = 16'($urandom);
    while (!cpu_ready && lat < 200) begin
      @(negedge clk); #2;
      lat++;
      cpu_req = (poke && lat == 2);
    end
    cpu_req = 1'b0;
    if (we) begin
      exp_lat = 2 + dly;
      if (was_hit) exp_hit++; else exp_miss++;
      ref_mem[a[5:0]] = d;
    end else if (was_hit) begin
      exp_lat = 2;
      exp_hit++;
      exp_rdata = ref_mem[a[5:0]];
    end else begin
      exp_lat = 3 + dly;
      exp_miss++;
      ref_cached[a[5:0]] = 1'b1;
      exp_rdata = ref_mem[a[5:0]];
    end
    check_val("latency", 32'(lat), 32'(exp_lat));
    check_val("cpu_rdata", 32'(cpu_rdata), 32'(exp_rdata));
    check_val("busy_respond", 32'(cpu_busy), 32'd1);
    @(negedge clk); #2;
    check_val("ready_pulse_end", 32'(cpu_ready), 32'd0);
    check_val("idle_busy", 32'(cpu_busy), 32'd0);
    check_val("idle_l1_addr", 32'(l1_addr), 32'd0);
    check_val("ready_count", 32'(n_ready - b_ready), 32'd1);
    check_val("mem_accesses", 32'(n_memacc - b_mem), 32'((we || !was_hit) ? 1 : 0));
    check_val("fill_count", 32'(n_fill - b_fill), 32'((!we && !was_hit) ? 1 : 0));
    check_val("wr_en_count", 32'(n_wr - b_wr), 32'((we && was_hit) ? 1 : 0));
    check_val("strobe_overlap", 32'(n_both), 32'd0);
    if (we || !was_hit) begin
      check_val("mem_addr", 32'(last_mem_addr), 32'(a));
      check_val("mem_we", 32'(last_mem_we), 32'(we));
    end
    if (we) check_val("mem_wdata", 32'(last_mem_wdata), 32'(d));
    if (we && was_hit) check_val("l1_wr_data", 32'(last_wr), 32'(d));
    if (!we && !was_hit) check_val("fill_data", 32'(last_fill), 32'(ref_mem[a[5:0]]));
    check_counters();
  endtask

  initial begin
    int b_ready;
    int b_wr;
    for (int i = 0; i < 64; i++) begin
      ref_mem[i]     = 16'($urandom);
      ref_cached[i]  = 1'b0;
      env_l1_vld[i]  = 1'b0;
      env_l1_data[i] = 16'd0;
    end
    ref_mem[0]  = 16'd23;
    ref_mem[16] = 16'd42;
    ref_cached[0]  = 1'b1;
    env_l1_vld[0]  = 1'b1;
    env_l1_data[0] = 16'd23;
    for (int i = 0; i < 64; i++) env_mem[i] = ref_mem[i];

    repeat (3) @(posedge clk);
    @(negedge clk); #2;
    check_idle_outputs();
    reset = 1'b0;
    @(negedge clk); #2;

    access(1'b0, 16'h0000, 16'd0, 1, 1'b0);
    access(1'b0, 16'h0010, 16'd0, 3, 1'b0);
    access(1'b0, 16'h0010, 16'd0, 1, 1'b0);
    access(1'b1, 16'h0000, 16'd31, 2, 1'b0);
    access(1'b1, 16'h0020, 16'd7, 1, 1'b0);
    access(1'b0, 16'h0020, 16'd0, 2, 1'b0);

    // A request pulsed while a miss is outstanding must be dropped.
    b_ready = n_ready;
    access(1'b0, 16'h0021, 16'd0, 4, 1'b1);
    repeat (8) @(negedge clk);
    #2;
    check_val("busy_reject_ready", 32'(n_ready - b_ready), 32'd1);
    check_val("busy_reject_idle", 32'(cpu_busy), 32'd0);

    for (int i = 0; i < 5; i++) access(1'b0, 16'h0000, 16'd0, 1, 1'b0);

    for (int i = 0; i < 150; i++) begin
      access(1'($urandom_range(0, 1)), 16'($urandom_range(0, 63)), 16'($urandom),
             int'($urandom_range(1, 4)), 1'b0);
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    // Abandon a write in MEM_WRITE; reset outranks a simultaneous request and ack.
    b_ready = n_ready;
    b_wr    = n_wr;
    g_ack_delay = 1000;
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 16'h0000; cpu_wdata = 16'h5555;
    @(posedge clk); #1;
    cpu_req = 1'b0;
    @(negedge clk); @(negedge clk); #2;
    check_val("mw_mem_req", 32'({mem_req, mem_we}), 32'd3);
    reset = 1'b1; cpu_req = 1'b1; ack_inject = 1'b1;
    @(negedge clk); #2;
    exp_hit = 0; exp_miss = 0; exp_rdata = 16'd0;
    check_idle_outputs();
    reset = 1'b0; cpu_req = 1'b0;
    repeat (5) @(negedge clk);
    #2;
    check_val("abandon_busy", 32'(cpu_busy), 32'd0);
    check_val("abandon_ready", 32'(n_ready - b_ready), 32'd0);
    check_val("abandon_wr_en", 32'(n_wr - b_wr), 32'd0);
    check_val("abandon_mem_req", 32'(mem_req), 32'd0);

    for (int i = 0; i < 20; i++)
      access(1'($urandom_range(0, 1)), 16'($urandom_range(0, 63)), 16'($urandom),
             int'($urandom_range(1, 3)), 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
